// File: rtl/ray_tag_dispatcher_pkg.sv
// Shared types for the normalization front end: ray direction, tagged ray and dispatcher state.
// Q_BITS only sets the fixed-point scale; nothing in the dispatcher does arithmetic on it.
package ray_tag_dispatcher_pkg;

    localparam int WIDTH    = 16;
    localparam int Q_BITS   = 14;
    localparam int TAG_SIZE = 5;

    localparam logic [WIDTH-1:0] ONE_FX = WIDTH'(1) << Q_BITS;

    typedef struct packed {
        logic signed [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] y;
        logic signed [WIDTH-1:0] z;
    } ray_dir_t;

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        ray_dir_t            dir;
    } tagged_ray_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } disp_state_t;

endpackage

// File: rtl/ray_tag_dispatcher_credit_counter.sv
// Up/down saturating occupancy counter; count updates one cycle after inc/dec.
// No backpressure of its own: o_at_limit is for the owner to stall inc, o_underflow is sticky.
module ray_tag_dispatcher_credit_counter #(
    parameter int MAX = 32,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_at_limit,
    output logic          o_underflow
);

    logic [CW-1:0] r_count;
    logic          r_underflow;
    logic          w_at_limit;
    logic          w_empty;

    assign w_at_limit = (r_count == CW'(MAX));
    assign w_empty    = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            // Simultaneous inc and dec cancel, including at zero.
            case ({i_inc, i_dec})
                2'b10: begin
                    if (!w_at_limit) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_at_limit  = w_at_limit;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/ray_tag_dispatcher.sv
// Tags accepted rays sequentially and issues a start pulse one cycle after accept.
// Upstream stalls via combinational in_ready when credits run out or a drain is requested.
module ray_tag_dispatcher
    import ray_tag_dispatcher_pkg::*;
#(
    parameter int MAX_INFLIGHT = 32,
    parameter int ROB_DEPTH    = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  ray_dir_t                             ray_in,
    output logic                                 issue_valid,
    output tagged_ray_t                          issue_out,
    input  logic                                 retire,
    input  logic                                 drain_req,
    output logic                                 drained,
    output logic [$clog2(MAX_INFLIGHT + 1)-1:0]  inflight,
    output logic                                 retire_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > (1 << TAG_SIZE) || MAX_INFLIGHT > ROB_DEPTH) begin : g_cfg_check
        $error("ray_tag_dispatcher: MAX_INFLIGHT must be 1..min(2**TAG_SIZE, ROB_DEPTH)");
    end

    disp_state_t         r_state;
    logic                r_issue_valid;
    tagged_ray_t         r_issue_out;
    logic [TAG_SIZE-1:0] r_next_tag;
    logic                r_drained;

    logic                w_in_ready;
    logic                w_accept;
    logic [CW-1:0]       w_inflight;
    logic                w_at_limit;
    logic                w_underflow;

    // Ready looks only at registered occupancy, so a same-cycle retire never shortens the path.
    assign w_in_ready = !reset && (r_state == ST_RUN) && !w_at_limit && !drain_req;
    assign w_accept   = in_valid && w_in_ready;

    ray_tag_dispatcher_credit_counter #(
        .MAX (MAX_INFLIGHT)
    ) u_credits (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_accept),
        .i_dec       (retire),
        .o_count     (w_inflight),
        .o_at_limit  (w_at_limit),
        .o_underflow (w_underflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_issue_valid <= 1'b0;
            r_issue_out   <= '0;
            r_next_tag    <= '0;
            r_drained     <= 1'b0;
        end else begin
            r_issue_valid <= w_accept;
            if (w_accept) begin
                r_issue_out <= '{tag: r_next_tag, dir: ray_in};
                r_next_tag  <= TAG_SIZE'(r_next_tag + 1'b1);
            end

            case (r_state)
                ST_RUN: begin
                    if (drain_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_inflight == '0 && !r_issue_valid) begin
                        r_state   <= ST_DONE;
                        r_drained <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!drain_req) begin
                        r_state   <= ST_RUN;
                        r_drained <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_drained <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign issue_valid = r_issue_valid;
    assign issue_out   = r_issue_out;
    assign drained     = r_drained;
    assign inflight    = w_inflight;
    assign retire_err  = w_underflow;

endmodule

// File: tb/tb_ray_tag_dispatcher.sv
// Directed bench for ray_tag_dispatcher with a queue-based reference model checked every cycle.
module tb_ray_tag_dispatcher;
    import ray_tag_dispatcher_pkg::*;

    localparam int MAXI  = 4;
    localparam int NTAGS = 1 << TAG_SIZE;
    localparam int MD_RUN = 0, MD_DRAIN = 1, MD_DONE = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    ray_dir_t    ray_in;
    logic        issue_valid;
    tagged_ray_t issue_out;
    logic        retire;
    logic        drain_req;
    logic        drained;
    logic [$clog2(MAXI + 1)-1:0] inflight;
    logic        retire_err;

    ray_tag_dispatcher #(
        .MAX_INFLIGHT (MAXI),
        .ROB_DEPTH    (MAXI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ray_in      (ray_in),
        .issue_valid (issue_valid),
        .issue_out   (issue_out),
        .retire      (retire),
        .drain_req   (drain_req),
        .drained     (drained),
        .inflight    (inflight),
        .retire_err  (retire_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic ray_dir_t mk(input int i);
        ray_dir_t r;
        r.x = ONE_FX + 16'(i);
        r.y = 16'(16'hA000 | i);
        r.z = 16'(i * 7);
        return r;
    endfunction

    // Reference model: outstanding rays are a queue of tags; occupancy is its size.
    int          q[$];
    int          m_tag = 0;
    bit          m_ivld = 1'b0;
    tagged_ray_t m_iout = '0;
    bit          m_err = 1'b0;
    int          m_mode = MD_RUN;
    int          m_acc_total = 0;

    function automatic bit model_ready();
        return !reset && m_mode == MD_RUN && q.size() < MAXI && !drain_req;
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = in_valid && model_ready();
        if (reset) begin
            q.delete();
            m_tag  = 0;
            m_ivld = 1'b0;
            m_iout = '0;
            m_err  = 1'b0;
            m_mode = MD_RUN;
        end else begin
            case (m_mode)
                MD_RUN:   if (drain_req) m_mode = MD_DRAIN;
                MD_DRAIN: if (q.size() == 0 && !m_ivld) m_mode = MD_DONE;
                default:  if (!drain_req) m_mode = MD_RUN;
            endcase
            if (acc) begin
                q.push_back(m_tag);
                m_iout.tag = TAG_SIZE'(m_tag);
                m_iout.dir = ray_in;
                m_tag = (m_tag + 1) % NTAGS;
                m_acc_total++;
            end
            if (retire) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1'b1;
            end
            m_ivld = acc;
        end
    end

    tagged_ray_t seen[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(model_ready()));
            check("issue_valid", 64'(issue_valid), 64'(m_ivld));
            if (m_ivld) check("issue_out", 64'(issue_out), 64'(m_iout));
            check("inflight", 64'(inflight), 64'(q.size()));
            check("drained", 64'(drained), 64'(m_mode == MD_DONE));
            check("retire_err", 64'(retire_err), 64'(m_err));
            if (issue_valid === 1'b1) seen.push_back(issue_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; ray_in = '0; retire = 1'b0; drain_req = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_out", 64'(issue_out), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_drained", 64'(drained), 64'd0);
        check("rst_retire_err", 64'(retire_err), 64'd0);
        reset = 1'b0;

        // Four back-to-back accepts.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; ray_in = mk(i); step();
        end
        in_valid = 1'b0;
        step(); step();
        @(negedge clk);
        check("t1_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            check("t1_tag", 64'(seen[i].tag), 64'(i));
            check("t1_dir", 64'(seen[i].dir), 64'(mk(i)));
        end
        check("t1_inflight", 64'(inflight), 64'd4);

        // Credit limit: held in_valid stalls; one retire lets exactly one more through.
        in_valid = 1'b1; ray_in = mk(4);
        step(); step();
        @(negedge clk);
        check("t2_stall_ready", 64'(in_ready), 64'd0);
        retire = 1'b1; step(); retire = 1'b0;
        step(); step(); step();
        in_valid = 1'b0; step();
        @(negedge clk);
        check("t2_count", 64'(seen.size()), 64'd5);
        if (seen.size() == 5) check("t2_tag", 64'(seen[4].tag), 64'd4);
        check("t2_inflight", 64'(inflight), 64'd4);

        // Same-cycle accept and retire at occupancy 2.
        retire = 1'b1; step(); step(); retire = 1'b0;
        in_valid = 1'b1; retire = 1'b1; ray_in = mk(5); step();
        in_valid = 1'b0; retire = 1'b0; step();
        @(negedge clk);
        check("t3_inflight", 64'(inflight), 64'd2);
        check("t3_count", 64'(seen.size()), 64'd6);
        if (seen.size() == 6) check("t3_tag", 64'(seen[5].tag), 64'd5);

        // Tag wrap with interleaved retires, up to 40 total accepts.
        for (int i = 0; i < 200 && m_acc_total < 40; i++) begin
            in_valid = 1'b1; retire = (i % 3 != 0); ray_in = mk(100 + i); step();
        end
        in_valid = 1'b0; retire = 1'b0; step(); step();
        check("t4_count", 64'(seen.size()), 64'd40);
        for (int i = 0; i < seen.size(); i++) check("t4_tag", 64'(seen[i].tag), 64'(i % NTAGS));
        if (seen.size() >= 33) begin
            check("t4_tag31", 64'(seen[31].tag), 64'd31);
            check("t4_tag32", 64'(seen[32].tag), 64'd0);
        end

        // Drain with three in flight.
        for (int i = 0; i < 8 && q.size() > 3; i++) begin retire = 1'b1; step(); end
        retire = 1'b0;
        for (int i = 0; i < 8 && q.size() < 3; i++) begin in_valid = 1'b1; step(); end
        in_valid = 1'b0;
        drain_req = 1'b1; in_valid = 1'b1;
        step();
        @(negedge clk);
        check("t5_ready_low", 64'(in_ready), 64'd0);
        check("t5_inflight3", 64'(inflight), 64'd3);
        step(); step();
        for (int k = 0; k < 3; k++) begin retire = 1'b1; step(); end
        retire = 1'b0;
        @(negedge clk);
        check("t5_drained_p1", 64'(drained), 64'd0);
        step();
        @(negedge clk);
        check("t5_drained_p2", 64'(drained), 64'd1);
        in_valid = 1'b0; drain_req = 1'b0; step();
        @(negedge clk);
        check("t5_drained_fall", 64'(drained), 64'd0);
        base = seen.size();
        in_valid = 1'b1; ray_in = mk(77); step();
        in_valid = 1'b0; step();
        check("t5_count", 64'(seen.size()), 64'(base + 1));
        if (seen.size() == base + 1) check("t5_tag", 64'(seen[base].tag), 64'd8);

        // Underflow error is sticky.
        retire = 1'b1; step(); step(); retire = 1'b0;
        @(negedge clk);
        check("t6_err", 64'(retire_err), 64'd1);
        check("t6_inflight", 64'(inflight), 64'd0);
        step(); step();
        @(negedge clk);
        check("t6_err_sticky", 64'(retire_err), 64'd1);

        // Reset mid-burst clears everything and restarts tags.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin ray_in = mk(200 + i); step(); end
        reset = 1'b1; step();
        @(negedge clk);
        check("t7_issue_valid", 64'(issue_valid), 64'd0);
        check("t7_issue_out", 64'(issue_out), 64'd0);
        check("t7_inflight", 64'(inflight), 64'd0);
        check("t7_retire_err", 64'(retire_err), 64'd0);
        check("t7_drained", 64'(drained), 64'd0);
        check("t7_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0; ray_in = mk(300); step();
        in_valid = 1'b0; step();
        if (seen.size() > 0) check("t7_tag_restart", 64'(seen[seen.size() - 1].tag), 64'd0);

        // Drain from empty: RUN -> DRAIN -> DONE over two cycles.
        retire = 1'b1; step(); retire = 1'b0;
        drain_req = 1'b1; step();
        @(negedge clk);
        check("t8_drained_c1", 64'(drained), 64'd0);
        step();
        @(negedge clk);
        check("t8_drained_c2", 64'(drained), 64'd1);
        drain_req = 1'b0; step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
